rf_wb_arbiter: RTL and testbench

// Write-back controller for the 32x32 register file: shares its single write port

---
 rtl/rf_wb_arbiter_if.sv | 56 +++++
 rtl/rf_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus bundle: ALU/MEM producer handshakes, issue/decode queries,
// register-file write port and scoreboard view.
interface rf_wb_arbiter_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
);
    localparam int unsigned AW = $clog2(NREG);

    // ALU result producer
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;

    // Load return producer
    logic            mem_valid;
    logic            mem_ready;
    logic [AW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_data;

    // Decode issue and hazard query
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   dec_rs1;
    logic [AW-1:0]   dec_rs2;
    logic [AW-1:0]   dec_rd;
    logic            dec_stall;

    // Register-file write port and scoreboard
    logic            rf_we;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] pend;

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  iss_valid, iss_rd, dec_rs1, dec_rs2, dec_rd,
        output dec_stall,
        output rf_we, rf_waddr, rf_wdata, pend
    );

    // Pipeline / register-file side
    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output iss_valid, iss_rd, dec_rs1, dec_rs2, dec_rd,
        input  dec_stall,
        input  rf_we, rf_waddr, rf_wdata, pend
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: shares the single RF write port between a
// buffered ALU result path and an unbuffered load return path, and keeps the
// pending-write scoreboard that stalls decode on RAW/WAW hazards.
module rf_wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREG       = 32,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

    // ALU result buffer
    logic [AW-1:0]   fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]   rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]   count,  count_nxt;

    // Arbitration
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            take_mem;
    logic            wb_fire;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    // Registered write port and scoreboard
    logic            rf_we_q,    rf_we_nxt;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_nxt;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_nxt;
    logic [NREG-1:0] pend_q,     pend_nxt;

    // Priority select: a full buffer drains first so ALU results cannot starve,
    // otherwise the unbuffered load path wins over buffered ALU results.
    always_comb begin
        fifo_full  = (count == DEPTH_CNT);
        fifo_empty = (count == '0);
        push       = bus.alu_valid && !fifo_full;
        take_mem   = bus.mem_valid && !fifo_full;
        pop        = fifo_full || (!bus.mem_valid && !fifo_empty);
        wb_fire    = take_mem || pop;
        wb_rd      = take_mem ? bus.mem_rd   : fifo_rd[rd_ptr];
        wb_data    = take_mem ? bus.mem_data : fifo_data[rd_ptr];
    end

    // Handshake readiness from the registered occupancy only
    assign bus.alu_ready = !fifo_full;
    assign bus.mem_ready = !fifo_full;

    // Buffer pointer and occupancy next-state; pointers wrap at the depth
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (push) begin
            wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
        end
        if (pop) begin
            rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
        end
        count_nxt = count + CW'(push) - CW'(pop);
    end

    // Write-port next-state; x0 results are consumed without a write
    always_comb begin
        rf_we_nxt    = wb_fire && (wb_rd != '0);
        rf_waddr_nxt = rf_waddr_q;
        rf_wdata_nxt = rf_wdata_q;
        if (rf_we_nxt) begin
            rf_waddr_nxt = wb_rd;
            rf_wdata_nxt = wb_data;
        end
    end

    // Scoreboard next-state: retire on the write edge, issue set overrides it
    always_comb begin
        pend_nxt = pend_q;
        if (rf_we_q) begin
            pend_nxt[rf_waddr_q] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != '0)) begin
            pend_nxt[bus.iss_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pend_q     <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            rd_ptr     <= rd_ptr_nxt;
            count      <= count_nxt;
            rf_we_q    <= rf_we_nxt;
            rf_waddr_q <= rf_waddr_nxt;
            rf_wdata_q <= rf_wdata_nxt;
            pend_q     <= pend_nxt;
        end
    end

    // Buffer storage; contents are don't-care while the slot is not occupied
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= bus.alu_rd;
            fifo_data[wr_ptr] <= bus.alu_data;
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.pend     = pend_q;

    // Decode hazard query: any source or the destination still pending
    assign bus.dec_stall = pend_q[bus.dec_rs1] | pend_q[bus.dec_rs2] | pend_q[bus.dec_rd];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: ALU-only latency, contention, starvation
// guard, scoreboard set/clear, x0 handling and reset mid-operation.
module tb_rf_wb_arbiter;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    rf_wb_arbiter_if #(.XLEN(32), .NREG(32)) bus ();

    rf_wb_arbiter #(.XLEN(32), .NREG(32), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.iss_valid = 1'b0; bus.iss_rd = '0;
        bus.dec_rs1 = '0; bus.dec_rs2 = '0; bus.dec_rd = '0;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
    endtask

    task automatic mem(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.mem_valid = v; bus.mem_rd = rd; bus.mem_data = d;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_rf_we",     64'(bus.rf_we),     64'd0);
        chk("reset_rf_waddr",  64'(bus.rf_waddr),  64'd0);
        chk("reset_rf_wdata",  64'(bus.rf_wdata),  64'd0);
        chk("reset_pend",      64'(bus.pend),      64'd0);
        chk("reset_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("reset_mem_ready", 64'(bus.mem_ready), 64'd1);
        chk("reset_dec_stall", 64'(bus.dec_stall), 64'd0);
        rst = 1'b0;
        tick();

        // ALU only: accepted at edge 1, written after edge 2, one-cycle pulse
        alu(1'b1, 5'd5, 32'h1234);
        tick();
        chk("alu_e1_we", 64'(bus.rf_we), 64'd0);
        alu(1'b0, 5'd0, 32'h0);
        tick();
        chk("alu_e2_we",    64'(bus.rf_we),    64'd1);
        chk("alu_e2_waddr", 64'(bus.rf_waddr), 64'd5);
        chk("alu_e2_wdata", 64'(bus.rf_wdata), 64'h1234);
        tick();
        chk("alu_e3_we", 64'(bus.rf_we), 64'd0);

        // Contention: load goes first, ALU result one cycle later
        mem(1'b1, 5'd7, 32'hAAAA);
        alu(1'b1, 5'd3, 32'h5555);
        tick();
        chk("cont_mem_we",    64'(bus.rf_we),    64'd1);
        chk("cont_mem_waddr", 64'(bus.rf_waddr), 64'd7);
        chk("cont_mem_wdata", 64'(bus.rf_wdata), 64'hAAAA);
        mem(1'b0, 5'd0, 32'h0);
        alu(1'b0, 5'd0, 32'h0);
        tick();
        chk("cont_alu_we",    64'(bus.rf_we),    64'd1);
        chk("cont_alu_waddr", 64'(bus.rf_waddr), 64'd3);
        chk("cont_alu_wdata", 64'(bus.rf_wdata), 64'h5555);
        tick();
        chk("cont_idle_we", 64'(bus.rf_we), 64'd0);

        // Starvation guard: fill the buffer behind a stream of loads
        mem(1'b1, 5'd12, 32'hC12);
        alu(1'b1, 5'd10, 32'hA10);
        tick();
        chk("starv_a_waddr",     64'(bus.rf_waddr),  64'd12);
        chk("starv_a_alu_ready", 64'(bus.alu_ready), 64'd1);
        mem(1'b1, 5'd13, 32'hC13);
        alu(1'b1, 5'd11, 32'hA11);
        tick();
        chk("starv_b_waddr",     64'(bus.rf_waddr),  64'd13);
        chk("starv_b_mem_ready", 64'(bus.mem_ready), 64'd0);
        chk("starv_b_alu_ready", 64'(bus.alu_ready), 64'd0);
        mem(1'b1, 5'd14, 32'hC14);
        alu(1'b1, 5'd15, 32'hA15);
        tick();
        chk("starv_c_waddr",     64'(bus.rf_waddr),  64'd10);
        chk("starv_c_wdata",     64'(bus.rf_wdata),  64'hA10);
        chk("starv_c_mem_ready", 64'(bus.mem_ready), 64'd1);
        tick();
        chk("starv_d_waddr",     64'(bus.rf_waddr),  64'd14);
        chk("starv_d_alu_ready", 64'(bus.alu_ready), 64'd0);
        mem(1'b0, 5'd0, 32'h0);
        alu(1'b0, 5'd0, 32'h0);
        tick();
        chk("starv_e_waddr", 64'(bus.rf_waddr), 64'd11);
        chk("starv_e_wdata", 64'(bus.rf_wdata), 64'hA11);
        tick();
        chk("starv_f_waddr", 64'(bus.rf_waddr), 64'd15);
        chk("starv_f_wdata", 64'(bus.rf_wdata), 64'hA15);
        tick();
        chk("starv_g_we", 64'(bus.rf_we), 64'd0);

        // Scoreboard: issue sets, write-back edge clears, same-edge set wins
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        tick();
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
        chk("sb_set_pend", 64'(bus.pend), 64'h200);
        bus.dec_rs1 = 5'd9;
        #1;
        chk("sb_rs1_stall", 64'(bus.dec_stall), 64'd1);
        bus.dec_rs1 = 5'd0; bus.dec_rd = 5'd8;
        #1;
        chk("sb_nohaz_stall", 64'(bus.dec_stall), 64'd0);
        bus.dec_rd = 5'd9;
        #1;
        chk("sb_waw_stall", 64'(bus.dec_stall), 64'd1);
        bus.dec_rd = 5'd0;
        mem(1'b1, 5'd9, 32'h99);
        tick();
        mem(1'b0, 5'd0, 32'h0);
        chk("sb_wb_we",   64'(bus.rf_we), 64'd1);
        chk("sb_wb_pend", 64'(bus.pend),  64'h200);
        tick();
        chk("sb_clr_pend", 64'(bus.pend), 64'd0);
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        tick();
        bus.iss_valid = 1'b0;
        mem(1'b1, 5'd9, 32'h98);
        tick();
        mem(1'b0, 5'd0, 32'h0);
        chk("sb_re_we", 64'(bus.rf_we), 64'd1);
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        tick();
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
        chk("sb_setwins_pend", 64'(bus.pend), 64'h200);
        tick();
        chk("sb_setwins_hold", 64'(bus.pend), 64'h200);
        mem(1'b1, 5'd9, 32'h97);
        tick();
        mem(1'b0, 5'd0, 32'h0);
        tick();
        chk("sb_final_pend", 64'(bus.pend), 64'd0);

        // x0 destination: accepted, never written, scoreboard untouched
        alu(1'b1, 5'd0, 32'hFFFF);
        #1;
        chk("x0_alu_ready", 64'(bus.alu_ready), 64'd1);
        tick();
        alu(1'b0, 5'd0, 32'h0);
        chk("x0_e1_we", 64'(bus.rf_we), 64'd0);
        tick();
        chk("x0_e2_we",   64'(bus.rf_we), 64'd0);
        chk("x0_e2_pend", 64'(bus.pend),  64'd0);
        tick();
        chk("x0_e3_we",        64'(bus.rf_we),     64'd0);
        chk("x0_e3_alu_ready", 64'(bus.alu_ready), 64'd1);

        // Reset mid-operation with a full buffer and a pending register
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
        tick();
        bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
        chk("rmid_pend", 64'(bus.pend), 64'h10);
        mem(1'b1, 5'd20, 32'hC20);
        alu(1'b1, 5'd21, 32'hA21);
        tick();
        mem(1'b1, 5'd22, 32'hC22);
        alu(1'b1, 5'd23, 32'hA23);
        tick();
        mem(1'b0, 5'd0, 32'h0);
        alu(1'b0, 5'd0, 32'h0);
        chk("rmid_full_alu_ready", 64'(bus.alu_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmid_rst_we",        64'(bus.rf_we),     64'd0);
        chk("rmid_rst_pend",      64'(bus.pend),      64'd0);
        chk("rmid_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("rmid_rst_waddr",     64'(bus.rf_waddr),  64'd0);
        tick();
        chk("rmid_post1_we", 64'(bus.rf_we), 64'd0);
        tick();
        chk("rmid_post2_we",        64'(bus.rf_we),     64'd0);
        chk("rmid_post2_mem_ready", 64'(bus.mem_ready), 64'd1);
        chk("rmid_post2_pend",      64'(bus.pend),      64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
